dds_step_calc: RTL and testbench

Sequential, parametrised frequency-to-phase-step converter for the DDS sine generator. It accepts a requested output frequency in Hz and computes the phase-accumulator increment with an exact restoring division: step = round(freq · 2^PHASE_W / F_CLK). It replaces the fixed 16-bit → 10-bit threshold ladder. It sits between the UART/command decoder (frequency register write) and the phase accumulator of each carrier NCO.

---
 rtl/dds_pkg.sv | 15 +
 rtl/dds_step_calc_seq_udiv.sv | 74 +++++++
 rtl/dds_step_calc.sv | 94 +++++++++
 tb/tb_dds_step_calc.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/dds_pkg.sv
// Shared constants and FSM state encoding for the DDS frequency-to-phase-step path.
package dds_pkg;

    localparam int unsigned DDS_F_CLK   = 2764815;
    localparam int unsigned DDS_FREQ_W  = 16;
    localparam int unsigned DDS_PHASE_W = 12;
    localparam int unsigned DDS_STEP_W  = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } dds_state_t;

endpackage

// File: rtl/dds_step_calc_seq_udiv.sv
// Generic restoring unsigned divider, one quotient bit per clock, MSB first.
// done pulses the cycle after the last bit; quo is held until the next start.
module seq_udiv #(
    parameter int unsigned NUM_W = 29,
    parameter int unsigned DEN_W = 23
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [NUM_W-1:0] num,
    input  logic [DEN_W-1:0] den,
    output logic             done,
    output logic [NUM_W-1:0] quo
);
    localparam int unsigned CNT_W = $clog2(NUM_W);

    logic [NUM_W-1:0] sh;
    logic [DEN_W-1:0] rem;
    logic [CNT_W-1:0] left;
    logic             run;

    logic [DEN_W-1:0] r_in;
    logic             b_in;
    logic [DEN_W:0]   trial;
    logic             ge;
    logic [DEN_W-1:0] r_nxt;

    // The first bit is resolved on the start edge itself, straight from num,
    // so the final quotient is registered one cycle before done is seen upstream.
    always_comb begin
        if (run) begin
            r_in = rem;
            b_in = sh[NUM_W-1];
        end else begin
            r_in = '0;
            b_in = num[NUM_W-1];
        end
        trial = {r_in, b_in};
        ge    = (trial >= {1'b0, den});
        r_nxt = ge ? DEN_W'(trial - {1'b0, den}) : trial[DEN_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sh   <= '0;
            rem  <= '0;
            quo  <= '0;
            left <= '0;
            run  <= 1'b0;
            done <= 1'b0;
        end else begin
            done <= 1'b0;
            if (!run) begin
                if (start) begin
                    sh   <= num << 1;
                    rem  <= r_nxt;
                    quo  <= NUM_W'(ge);
                    left <= CNT_W'(NUM_W - 1);
                    run  <= 1'b1;
                end
            end else begin
                sh   <= sh << 1;
                rem  <= r_nxt;
                quo  <= {quo[NUM_W-2:0], ge};
                left <= left - CNT_W'(1);
                if (left == CNT_W'(1)) begin
                    run  <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/dds_step_calc.sv
// Frequency (Hz) to DDS phase step: step = round(freq * 2^PHASE_W / F_CLK),
// computed by a sequential restoring divider, then saturated / clamped to 1.
module dds_step_calc
    import dds_pkg::*;
#(
    parameter int unsigned F_CLK   = DDS_F_CLK,
    parameter int unsigned FREQ_W  = DDS_FREQ_W,
    parameter int unsigned PHASE_W = DDS_PHASE_W,
    parameter int unsigned STEP_W  = DDS_STEP_W,
    parameter bit          ROUND   = 1'b1,
    parameter bit          MIN_ONE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [FREQ_W-1:0] freq,
    output logic              busy,
    output logic              done,
    output logic [STEP_W-1:0] step,
    output logic              sat
);
    localparam int unsigned DIV_W = FREQ_W + PHASE_W + 1;
    localparam int unsigned R_W   = $clog2(F_CLK) + 1;

    localparam logic [DIV_W-1:0]  RND_OFS  = ROUND ? DIV_W'(F_CLK / 2) : '0;
    localparam logic [R_W-1:0]    DEN      = R_W'(F_CLK);
    localparam logic [STEP_W-1:0] RST_STEP = MIN_ONE ? STEP_W'(1) : '0;

    dds_state_t       state, state_nxt;
    logic             div_start;
    logic             div_done;
    logic [DIV_W-1:0] num;
    logic [DIV_W-1:0] quo;

    always_comb begin
        num = {1'b0, freq, {PHASE_W{1'b0}}} + RND_OFS;
    end

    seq_udiv #(
        .NUM_W (DIV_W),
        .DEN_W (R_W)
    ) u_div (
        .clk   (clk),
        .rst   (rst),
        .start (div_start),
        .num   (num),
        .den   (DEN),
        .done  (div_done),
        .quo   (quo)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        div_start = 1'b0;
        busy      = (state != IDLE);
        done      = (state == DONE);
        case (state)
            IDLE: begin
                if (start) begin
                    div_start = 1'b1;
                    state_nxt = CALC;
                end
            end
            CALC:    if (div_done) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Result is captured on the CALC->DONE edge so it is valid during the done cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            step <= RST_STEP;
            sat  <= 1'b0;
        end else if (state == CALC && div_done) begin
            if (|quo[DIV_W-1:STEP_W]) begin
                step <= '1;
                sat  <= 1'b1;
            end else if (MIN_ONE && quo[STEP_W-1:0] == '0) begin
                step <= STEP_W'(1);
                sat  <= 1'b0;
            end else begin
                step <= quo[STEP_W-1:0];
                sat  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dds_step_calc.sv
// Bench for dds_step_calc: directed vector table across four parameterisations,
// multi-cycle corner sequences, and a randomized back-to-back sweep against an arithmetic model.
module tb_dds_step_calc;

    localparam int unsigned F_CLK = 2764815;
    localparam int unsigned DIV_W = 29;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, start;
    logic [15:0] freq;

    logic       busy, done, sat;
    logic [9:0] step;
    logic       m0_busy, m0_done, m0_sat;
    logic [9:0] m0_step;
    logic       r0_busy, r0_done, r0_sat;
    logic [9:0] r0_step;
    logic       s6_busy, s6_done, s6_sat;
    logic [5:0] s6_step;

    dds_step_calc u_dut (
        .clk(clk), .rst(rst), .start(start), .freq(freq),
        .busy(busy), .done(done), .step(step), .sat(sat)
    );
    dds_step_calc #(.MIN_ONE(1'b0)) u_m0 (
        .clk(clk), .rst(rst), .start(start), .freq(freq),
        .busy(m0_busy), .done(m0_done), .step(m0_step), .sat(m0_sat)
    );
    dds_step_calc #(.ROUND(1'b0)) u_r0 (
        .clk(clk), .rst(rst), .start(start), .freq(freq),
        .busy(r0_busy), .done(r0_done), .step(r0_step), .sat(r0_sat)
    );
    dds_step_calc #(.STEP_W(6)) u_s6 (
        .clk(clk), .rst(rst), .start(start), .freq(freq),
        .busy(s6_busy), .done(s6_done), .step(s6_step), .sat(s6_sat)
    );

    int ntests = 0;
    int nfail  = 0;
    int acc_cnt  = 0;
    int done_cnt = 0;

    // An accept is start sampled while the default instance is idle and not in reset.
    always @(posedge clk) begin
        if (!rst && start && !busy) acc_cnt++;
        if (done) done_cnt++;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void model(input int unsigned f, input int unsigned sw,
                                  input bit rnd, input bit m1,
                                  output longint st, output longint sa);
        longint unsigned n, q, lim;
        n = f;
        n = n * 4096;
        if (rnd) n = n + F_CLK / 2;
        q   = n / F_CLK;
        lim = (64'd1 << sw) - 1;
        if (q > lim) begin
            st = lim; sa = 1;
        end else if (q == 0 && m1) begin
            st = 1; sa = 0;
        end else begin
            st = q; sa = 0;
        end
    endfunction

    task automatic accept(input logic [15:0] f);
        @(negedge clk);
        freq  = f;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        freq  = 16'($urandom);
        chk("accept_busy", busy, 1);
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!done && lat < 100) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    typedef struct {
        logic [15:0] f;
        int d_step;
        int m0_step;
        int r0_step;
        int s6_step;
        int s6_sat;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int lat, d0, a0;
        longint es, ea;
        logic [15:0] f;

        tbl[0] = '{16'd1000,  1,  1,  1,  1, 0};
        tbl[1] = '{16'd10000, 15, 15, 14, 15, 0};
        tbl[2] = '{16'd0,     1,  0,  1,  1, 0};
        tbl[3] = '{16'd65535, 97, 97, 97, 63, 1};
        tbl[4] = '{16'd40000, 59, 59, 59, 59, 0};
        tbl[5] = '{16'd43000, 64, 64, 63, 63, 1};
        tbl[6] = '{16'd2000,  3,  3,  2,  3, 0};
        tbl[7] = '{16'd337,   1,  0,  1,  1, 0};
        tbl[8] = '{16'd338,   1,  1,  1,  1, 0};

        rst = 1'b1; start = 1'b0; freq = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sat", sat, 0);
        chk("rst_step", step, 1);
        chk("rst_m0_step", m0_step, 0);
        chk("rst_s6_step", s6_step, 1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 9; i++) begin
            accept(tbl[i].f);
            wait_done(lat);
            chk("tbl_latency", lat, DIV_W);
            chk("tbl_step", step, tbl[i].d_step);
            chk("tbl_sat", sat, 0);
            chk("tbl_m0_step", m0_step, tbl[i].m0_step);
            chk("tbl_r0_step", r0_step, tbl[i].r0_step);
            chk("tbl_s6_step", s6_step, tbl[i].s6_step);
            chk("tbl_s6_sat", s6_sat, tbl[i].s6_sat);
            @(posedge clk);
        end

        // start while busy is ignored; start in the done cycle is ignored
        accept(16'd10000);
        repeat (9) @(posedge clk);
        @(negedge clk);
        freq = 16'd65535; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(lat);
        chk("busy_ign_latency", lat + 10, DIV_W);
        chk("busy_ign_step", step, 15);
        @(negedge clk);
        freq = 16'd2000; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk("donecyc_start_busy", busy, 0);
        @(posedge clk);
        #1;
        chk("donecyc_start_busy2", busy, 0);
        d0 = done_cnt;
        repeat (40) @(posedge clk);
        #1;
        chk("donecyc_no_done", done_cnt - d0, 0);
        chk("donecyc_step_held", step, 15);

        // reset mid-CALC aborts
        accept(16'd65535);
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_step", step, 1);
        chk("abort_sat", sat, 0);
        @(negedge clk);
        rst = 1'b0;
        d0 = done_cnt;
        repeat (40) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt - d0, 0);
        accept(16'd10000);
        wait_done(lat);
        chk("after_abort_latency", lat, DIV_W);
        chk("after_abort_step", step, 15);
        @(posedge clk);

        // rst and start together: rst wins
        @(negedge clk);
        rst = 1'b1; start = 1'b1; freq = 16'd65535;
        @(posedge clk);
        #1;
        chk("rst_start_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(posedge clk);
        #1;
        chk("rst_start_busy2", busy, 0);
        chk("rst_start_step", step, 1);

        // randomized back-to-back sweep at minimum start spacing
        a0 = acc_cnt;
        d0 = done_cnt;
        for (int i = 0; i < 1000; i++) begin
            if (i % 4 == 0) f = 16'($urandom_range(0, 2000));
            else            f = 16'($urandom);
            accept(f);
            wait_done(lat);
            chk("sweep_latency", lat, DIV_W);
            model(f, 10, 1'b1, 1'b1, es, ea);
            chk("sweep_step", step, es);
            chk("sweep_sat", sat, ea);
            model(f, 10, 1'b1, 1'b0, es, ea);
            chk("sweep_m0_step", m0_step, es);
            model(f, 10, 1'b0, 1'b1, es, ea);
            chk("sweep_r0_step", r0_step, es);
            model(f, 6, 1'b1, 1'b1, es, ea);
            chk("sweep_s6_step", s6_step, es);
            chk("sweep_s6_sat", s6_sat, ea);
            @(posedge clk);
        end
        #1;
        chk("sweep_accepts", acc_cnt - a0, 1000);
        chk("sweep_dones", done_cnt - d0, 1000);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
